// File: rtl/can_pkg.sv
// Shared constants, state encoding and the CRC-15 step for the CAN transmit framer.
package can_pkg;

  localparam logic [14:0] CRC_POLY     = 15'h4599;
  localparam int          EOF_BITS     = 7;
  localparam int          IFS_BITS     = 3;
  localparam int          STD_ARB_BITS = 13;
  localparam int          EXT_ARB_BITS = 33;
  localparam int          CTRL_BITS    = 6;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DELIM, S_ACK, S_ACK_DELIM, S_EOF, S_IFS
  } state_e;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic [14:0] shifted;
    shifted = {crc[13:0], 1'b0};
    if (din ^ crc[14]) crc15_step = shifted ^ CRC_POLY;
    else               crc15_step = shifted;
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 register: clear has priority over a shift of one data bit.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [14:0] crc
);

  logic [14:0] crc_q, crc_d;

  // next CRC value
  always_comb begin
    crc_d = crc_q;
    if (clr)     crc_d = 15'd0;
    else if (en) crc_d = crc15_step(crc_q, din);
    else         crc_d = crc_q;
  end

  // CRC register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= 15'd0;
    else      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_tx_framer.sv
// CAN 2.0 transmit framer: serialises a standard/extended frame with stuffing,
// CRC-15, arbitration readback and ACK-slot checking.
module can_tx_framer
  import can_pkg::*;
#(
  parameter int BIT_CYCLES = 8,
  parameter int SAMPLE_PT  = 5,
  parameter bit EXT_ID_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            tx_req,
  input  logic [28:0]     tx_id,
  input  logic            tx_ide,
  input  logic            tx_rtr,
  input  logic [3:0]      tx_dlc,
  input  logic [7:0][7:0] tx_data,
  input  logic            bit_in,
  output logic            tx_busy,
  output logic            tx_complete,
  output logic            tx_ack_err,
  output logic            tx_arb_lost,
  output logic            bit_out
);

  localparam int              BC_W      = $clog2(BIT_CYCLES);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_PRE    = BC_W'(BIT_CYCLES - 2);
  localparam logic [BC_W-1:0] BC_SAMPLE = BC_W'(SAMPLE_PT);

  state_e          state_q, state_d, adv_state, pos_state;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [5:0]      fcnt_q, fcnt_d, adv_fcnt, pos_fcnt, last_idx;
  logic [2:0]      run_q, run_d;
  logic            stuff_q, stuff_d, ext_q, ext_d, rtr_q, rtr_d;
  logic [28:0]     id_q, id_d;
  logic [3:0]      dlc_q, dlc_d;
  logic [63:0]     data_q, data_d;
  logic            ack_flag_q, ack_flag_d, busy_q, busy_d, complete_q, complete_d;
  logic            ack_err_q, ack_err_d, arb_lost_q, arb_lost_d, bit_out_q, bit_out_d;
  logic [32:0]     arb_v;
  logic [5:0]      ctrl_v;
  logic [6:0]      data_len;
  logic            bit_end, sample, pos_val, do_stuff, next_bit, crc_clr, crc_en;
  logic [14:0]     crc;

  assign bit_end = (bc_q == BC_LAST);
  assign sample  = (bc_q == BC_SAMPLE);

  can_crc15 u_crc (
    .clk (clk), .rst (rst), .clr (crc_clr), .en (crc_en), .din (next_bit), .crc (crc)
  );

  // frame contents and last index of the current field
  always_comb begin
    arb_v  = ext_q ? {1'b0, id_q[28:18], 1'b1, 1'b1, id_q[17:0], rtr_q}
                   : {1'b0, id_q[10:0], rtr_q, 20'd0};
    ctrl_v = {2'b00, dlc_q};
    if (rtr_q)              data_len = 7'd0;
    else if (dlc_q > 4'd8)  data_len = 7'd64;
    else                    data_len = {dlc_q, 3'b000};
    case (state_q)
      S_ARB:   last_idx = ext_q ? 6'(EXT_ARB_BITS - 1) : 6'(STD_ARB_BITS - 1);
      S_CTRL:  last_idx = 6'(CTRL_BITS - 1);
      S_DATA:  last_idx = 6'(data_len - 7'd1);
      S_CRC:   last_idx = 6'd14;
      S_EOF:   last_idx = 6'(EOF_BITS - 1);
      S_IFS:   last_idx = 6'(IFS_BITS - 1);
      default: last_idx = 6'd0;
    endcase
  end

  // while a stuff bit is on the wire, state/fcnt already point at the next frame bit
  always_comb begin
    adv_state = state_q;
    adv_fcnt  = fcnt_q + 6'd1;
    if (fcnt_q == last_idx) begin
      adv_fcnt = 6'd0;
      case (state_q)
        S_ARB:       adv_state = S_CTRL;
        S_CTRL:      adv_state = (data_len == 7'd0) ? S_CRC : S_DATA;
        S_DATA:      adv_state = S_CRC;
        S_CRC:       adv_state = S_CRC_DELIM;
        S_CRC_DELIM: adv_state = S_ACK;
        S_ACK:       adv_state = S_ACK_DELIM;
        S_ACK_DELIM: adv_state = S_EOF;
        S_EOF:       adv_state = S_IFS;
        default:     adv_state = S_IDLE;
      endcase
    end else begin
      adv_state = state_q;
    end
    pos_state = stuff_q ? state_q : adv_state;
    pos_fcnt  = stuff_q ? fcnt_q  : adv_fcnt;
    case (pos_state)
      S_ARB:   pos_val = arb_v[6'd32 - pos_fcnt];
      S_CTRL:  pos_val = ctrl_v[3'd5 - pos_fcnt[2:0]];
      S_DATA:  pos_val = data_q[6'd63 - pos_fcnt];
      S_CRC:   pos_val = crc[4'd14 - pos_fcnt[3:0]];
      default: pos_val = 1'b1;
    endcase
    do_stuff = !stuff_q && (run_q == 3'd5) && (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC});
    next_bit = do_stuff ? ~bit_out_q : pos_val;
  end

  // sequencing, capture, arbitration and ACK handling
  always_comb begin
    state_d    = state_q;    bc_d       = bc_q;       fcnt_d     = fcnt_q;
    run_d      = run_q;      stuff_d    = stuff_q;    ext_d      = ext_q;
    rtr_d      = rtr_q;      id_d       = id_q;       dlc_d      = dlc_q;
    data_d     = data_q;     ack_flag_d = ack_flag_q; busy_d     = busy_q;
    bit_out_d  = bit_out_q;  complete_d = 1'b0;       ack_err_d  = 1'b0;
    arb_lost_d = 1'b0;       crc_clr    = 1'b0;       crc_en     = 1'b0;
    if (state_q == S_IDLE) begin
      busy_d    = 1'b0;
      bit_out_d = 1'b1;
      if (tx_req) begin
        id_d       = tx_id;
        ext_d      = EXT_ID_EN ? tx_ide : 1'b0;
        rtr_d      = tx_rtr;
        dlc_d      = tx_dlc;
        data_d     = {tx_data[0], tx_data[1], tx_data[2], tx_data[3],
                      tx_data[4], tx_data[5], tx_data[6], tx_data[7]};
        state_d    = S_ARB;
        bc_d       = '0;
        fcnt_d     = 6'd0;
        stuff_d    = 1'b0;
        run_d      = 3'd1;
        ack_flag_d = 1'b0;
        busy_d     = 1'b1;
        bit_out_d  = 1'b0;
        crc_clr    = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      bc_d = bit_end ? '0 : bc_q + BC_W'(1);
      if (bit_end && state_q == S_IFS && fcnt_q == last_idx) begin
        state_d   = S_IDLE;
        bit_out_d = 1'b1;
      end else if (bit_end) begin
        state_d   = pos_state;
        fcnt_d    = pos_fcnt;
        stuff_d   = do_stuff;
        bit_out_d = next_bit;
        run_d     = (next_bit != bit_out_q) ? 3'd1 : (run_q == 3'd7) ? run_q : run_q + 3'd1;
        crc_en    = !do_stuff && (pos_state inside {S_ARB, S_CTRL, S_DATA});
      end else begin
        bit_out_d = bit_out_q;
      end
      if (state_q == S_IFS && fcnt_q == last_idx && bc_q == BC_PRE) begin
        complete_d = 1'b1;
        ack_err_d  = ack_flag_q;
        busy_d     = 1'b0;
      end else begin
        complete_d = 1'b0;
      end
      if (sample && state_q == S_ACK && bit_in) ack_flag_d = 1'b1;
      else                                      ack_flag_d = ack_flag_q;
      // recessive sent but dominant seen on a real ARB bit: back off at once
      if (sample && state_q == S_ARB && !stuff_q && bit_out_q && !bit_in) begin
        state_d    = S_IDLE;
        arb_lost_d = 1'b1;
        busy_d     = 1'b0;
        bit_out_d  = 1'b1;
        crc_en     = 1'b0;
      end else begin
        arb_lost_d = 1'b0;
      end
    end
    if (init) begin
      state_d    = S_IDLE; bc_d = '0; fcnt_d = 6'd0; run_d = 3'd0; stuff_d = 1'b0;
      ack_flag_d = 1'b0;   busy_d = 1'b0; complete_d = 1'b0; ack_err_d = 1'b0;
      arb_lost_d = 1'b0;   bit_out_d = 1'b1; crc_clr = 1'b1; crc_en = 1'b0;
    end else begin
      crc_clr = crc_clr;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE; bc_q <= '0; fcnt_q <= 6'd0; run_q <= 3'd0; stuff_q <= 1'b0;
      ext_q <= 1'b0; rtr_q <= 1'b0; id_q <= 29'd0; dlc_q <= 4'd0; data_q <= 64'd0;
      ack_flag_q <= 1'b0; busy_q <= 1'b0; complete_q <= 1'b0; ack_err_q <= 1'b0;
      arb_lost_q <= 1'b0; bit_out_q <= 1'b1;
    end else begin
      state_q <= state_d; bc_q <= bc_d; fcnt_q <= fcnt_d; run_q <= run_d; stuff_q <= stuff_d;
      ext_q <= ext_d; rtr_q <= rtr_d; id_q <= id_d; dlc_q <= dlc_d; data_q <= data_d;
      ack_flag_q <= ack_flag_d; busy_q <= busy_d; complete_q <= complete_d; ack_err_q <= ack_err_d;
      arb_lost_q <= arb_lost_d; bit_out_q <= bit_out_d;
    end
  end

  assign tx_busy     = busy_q;
  assign tx_complete = complete_q;
  assign tx_ack_err  = ack_err_q;
  assign tx_arb_lost = arb_lost_q;
  assign bit_out     = bit_out_q;

endmodule

// File: tb/tb_can_tx_framer.sv
// Randomised scoreboard bench for can_tx_framer: a bit-list reference model
// predicts each wire bitstream and outcome; a monitor captures and compares frames.
module tb_can_tx_framer;

  localparam int BC   = 4;
  localparam int SP   = 2;
  localparam int MAXC = 2048;

  typedef struct {
    logic [255:0] bits;
    logic [255:0] stf;
    int           n;
    bit           arb;
    int           arb_cyc;
    bit           ack_err;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0, init = 1'b0, tx_req = 1'b0;
  logic [28:0] tx_id = 29'd0;
  logic tx_ide = 1'b0, tx_rtr = 1'b0;
  logic [3:0] tx_dlc = 4'd0;
  logic [7:0][7:0] tx_data = '0;
  logic drv_dom = 1'b0;
  logic bit_in, tx_busy, tx_complete, tx_ack_err, tx_arb_lost, bit_out;

  int n_checks = 0, n_pass = 0;
  exp_t sb[$];
  exp_t me;
  bit capc[MAXC];
  int ncyc = 0, exp_cyc, bad;
  bit cap = 0, once_chk = 0, busy_prev = 0;
  bit last_bits[8];

  assign bit_in = bit_out & ~drv_dom;

  always #5 clk = ~clk;

  can_tx_framer #(.BIT_CYCLES(BC), .SAMPLE_PT(SP), .EXT_ID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .init(init), .tx_req(tx_req), .tx_id(tx_id), .tx_ide(tx_ide),
    .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data), .bit_in(bit_in),
    .tx_busy(tx_busy), .tx_complete(tx_complete), .tx_ack_err(tx_ack_err),
    .tx_arb_lost(tx_arb_lost), .bit_out(bit_out)
  );

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: list the unstuffed bits, CRC them, stuff, append the fixed tail.
  function automatic exp_t model(bit ext, logic [28:0] id, bit rtr, logic [3:0] dlc, logic [63:0] flat);
    bit u[$];
    logic [14:0] crc;
    bit fb, last;
    int nb, run, nunst;
    exp_t e;
    u.push_back(1'b0);
    if (ext) begin
      for (int i = 28; i >= 18; i--) u.push_back(id[i]);
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(id[i]);
    end else begin
      for (int i = 10; i >= 0; i--) u.push_back(id[i]);
    end
    u.push_back(rtr); u.push_back(1'b0); u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < nb * 8; i++) u.push_back(flat[63 - i]);
    crc = 15'd0;
    foreach (u[i]) begin
      fb  = u[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc = crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    nunst = u.size();
    e.bits = '0; e.stf = '0; e.n = 0; e.arb = 0; e.arb_cyc = 0; e.ack_err = 0;
    run = 0; last = 1'b0;
    for (int i = 0; i < nunst; i++) begin
      e.bits[e.n] = u[i]; e.n++;
      if (run > 0 && u[i] == last) run++; else run = 1;
      last = u[i];
      if (run == 5) begin
        e.bits[e.n] = ~last; e.stf[e.n] = 1'b1; e.n++;
        last = ~last; run = 1;
      end
    end
    for (int i = 0; i < 13; i++) begin e.bits[e.n] = 1'b1; e.n++; end
    return e;
  endfunction

  task automatic set_inputs(bit ext, logic [28:0] id, bit rtr, logic [3:0] dlc, logic [63:0] flat);
    tx_ide = ext; tx_id = id; tx_rtr = rtr; tx_dlc = dlc;
    for (int b = 0; b < 8; b++) tx_data[b] = flat[63 - 8*b -: 8];
  endtask

  // arb_mode: 0 none, 1 first recessive ARB bit, 2 random recessive ARB bit
  task automatic run_frame(bit ext, logic [28:0] id, bit rtr, logic [3:0] dlc, logic [63:0] flat,
                           bit ack_on, int arb_mode, bit pulses);
    exp_t e;
    int cand[$];
    int k, u, nlast;
    e = model(ext, id, rtr, dlc, flat);
    k = -1;
    if (arb_mode != 0) begin
      u = 0;
      for (int i = 0; i < e.n; i++) begin
        if (!e.stf[i]) begin
          if (u >= 1 && u < (ext ? 33 : 13) && e.bits[i]) cand.push_back(i);
          u++;
        end
      end
      if (cand.size() > 0) k = (arb_mode == 1) ? cand[0] : cand[$urandom_range(cand.size() - 1)];
    end
    if (k >= 0) begin e.arb = 1; e.arb_cyc = k * BC + SP + 1; end
    else e.ack_err = !ack_on;
    sb.push_back(e);
    set_inputs(ext, id, rtr, dlc, flat);
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
    nlast = (k >= 0) ? k + 1 : e.n;
    for (int i = 0; i < nlast; i++) begin
      drv_dom = (ack_on && k < 0 && i == e.n - 12) || (i == k);
      tx_req  = pulses && (i == 20 || i == 60);
      if (tx_req) tx_id = 29'($urandom);
      repeat (BC) @(posedge clk);
      #1;
    end
    drv_dom = 1'b0; tx_req = 1'b0;
    if (k >= 0) begin repeat (2) @(posedge clk); #1; end
  endtask

  task automatic start_raw(int nbits);
    set_inputs(1'b0, 29'h0A5, 1'b0, 4'd8, 64'h0123_4567_89AB_CDEF);
    tx_req = 1'b1;
    @(posedge clk); #1;
    tx_req = 1'b0;
    repeat (nbits * BC) @(posedge clk);
    #1;
  endtask

  // Monitor: capture each frame cycle by cycle and settle it against the scoreboard.
  always @(negedge clk) begin
    if (!rst || init) begin
      cap = 0; once_chk = 0;
    end else begin
      if (once_chk) begin
        chk(tx_complete == 1'b0, "complete_single", tx_complete, 0);
        once_chk = 0;
      end
      if (!cap && tx_busy && !busy_prev) begin cap = 1; ncyc = 0; end
      if (cap) begin
        if (tx_complete || tx_arb_lost) begin
          if (tx_complete) begin capc[ncyc] = bit_out; ncyc++; end
          cap = 0;
          if (sb.size() == 0) chk(1'b0, "unexpected_frame", 1, 0);
          else begin
            me = sb.pop_front();
            chk(tx_arb_lost == me.arb, "event_kind", tx_arb_lost, me.arb);
            exp_cyc = me.arb ? me.arb_cyc : me.n * BC;
            chk(ncyc == exp_cyc, "frame_cycles", ncyc, exp_cyc);
            bad = -1;
            for (int c = 0; c < ncyc && c < exp_cyc; c++)
              if (bad < 0 && capc[c] !== me.bits[c / BC]) bad = c;
            chk(bad < 0, "bitstream_first_bad_cycle", bad, -1);
            for (int i = 0; i < 8; i++) last_bits[i] = capc[i * BC];
            if (me.arb) begin
              chk(bit_out && !tx_busy && !tx_complete, "arb_release",
                  {bit_out, tx_busy, tx_complete}, 3'b100);
            end else begin
              chk(tx_ack_err == me.ack_err, "ack_err", tx_ack_err, me.ack_err);
              chk(!tx_busy, "busy_at_complete", tx_busy, 0);
              once_chk = 1;
            end
          end
        end else begin
          capc[ncyc] = bit_out; ncyc++;
          if (ncyc >= MAXC) begin chk(1'b0, "frame_timeout", ncyc, MAXC); cap = 0; end
        end
      end else if (tx_complete || tx_arb_lost) begin
        chk(1'b0, "spurious_event", {tx_complete, tx_arb_lost}, 0);
      end
    end
    busy_prev = tx_busy;
  end

  initial begin
    logic [7:0] pre;
    logic [63:0] rnd;
    repeat (3) @(posedge clk);
    #1;
    chk(bit_out == 1'b1, "reset_bit_out", bit_out, 1);
    chk({tx_busy, tx_complete, tx_ack_err, tx_arb_lost} == 4'b0, "reset_flags",
        {tx_busy, tx_complete, tx_ack_err, tx_arb_lost}, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    run_frame(1'b0, 29'h123, 1'b0, 4'd1, {8'hAA, 56'd0}, 1'b1, 0, 1'b0);
    run_frame(1'b0, 29'h7FF, 1'b0, 4'd0, 64'd0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 8; i++) pre[7 - i] = last_bits[i];
    chk(pre == 8'b0111_1101, "id7ff_stuff_prefix", pre, 8'b0111_1101);
    run_frame(1'b0, 29'h7FF, 1'b0, 4'd0, 64'd0, 1'b0, 0, 1'b0);
    run_frame(1'b0, 29'h7FF, 1'b0, 4'd0, 64'd0, 1'b1, 1, 1'b0);
    run_frame(1'b1, 29'h1ABCDEF, 1'b0, 4'd12, {$urandom, $urandom}, 1'b1, 0, 1'b1);

    // asynchronous reset in the middle of the data field
    start_raw(24);
    #2 rst = 1'b0;
    #1;
    chk(bit_out == 1'b1, "rst_async_bit_out", bit_out, 1);
    chk(tx_busy == 1'b0, "rst_async_busy", tx_busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    run_frame(1'b0, 29'h2C3, 1'b0, 4'd2, {16'h5A0F, 48'd0}, 1'b1, 0, 1'b0);

    // synchronous init mid-frame
    start_raw(10);
    init = 1'b1;
    @(posedge clk); #1;
    chk({tx_busy, bit_out} == 2'b01, "init_clear", {tx_busy, bit_out}, 2'b01);
    init = 1'b0;
    @(posedge clk); #1;

    for (int f = 0; f < 8; f++) begin
      rnd = {$urandom, $urandom};
      run_frame(1'($urandom), 29'($urandom), ($urandom_range(3) == 0), 4'($urandom),
                rnd, ($urandom_range(3) != 0), (f >= 6) ? 2 : 0, 1'b0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_tx_framer.md
# can_tx_framer

Parametrised CAN 2.0 transmit framer, successor to the simple TX serializer. It takes a standard (11-bit) or extended (29-bit) frame request and serialises SOF through IFS at a programmable bit rate. It inserts stuff bits and a CRC-15, checks arbitration and the ACK slot on the bus readback, and reports completion, lost arbitration or a missing ACK. It sits between the host register interface and the bus transceiver.

## Interface
- BIT_CYCLES, 8: clk cycles per CAN bit; must be at least 4.
- SAMPLE_PT, 5: cycle index within a bit at which bit_in is sampled; valid range 1..BIT_CYCLES-1.
- EXT_ID_EN, 1: when 0, tx_ide is ignored and every frame is standard.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- init  in  1  synchronous clear, same effect as reset; highest synchronous priority.
- tx_req  in  1  frame request; sampled only while idle.
- tx_id  in  29  identifier; standard frames use [10:0].
- tx_ide  in  1  extended-frame select.
- tx_rtr  in  1  remote frame; no data field is sent.
- tx_dlc  in  4  data length code.
- tx_data  in  8x8  payload; byte 0 goes first, MSB first.
- bit_in  in  1  bus readback; 0 is dominant.
- tx_busy  out  1  a frame is in progress.
- tx_complete  out  1  one-cycle pulse at the end of IFS.
- tx_ack_err  out  1  coincides with tx_complete; high when the ACK slot was sampled recessive.
- tx_arb_lost  out  1  one-cycle pulse when arbitration is lost.
- bit_out  out  1  bus drive.

## Operation
- Reset and init: tx_busy, tx_complete, tx_ack_err and tx_arb_lost are 0; bit_out is 1 (recessive); state is IDLE.
- IDLE: when tx_req is seen, capture all tx_* inputs, then go to ARB. tx_req is ignored while busy.
- State sequence: IDLE, ARB, CTRL, DATA, CRC, CRC_DELIM, ACK, ACK_DELIM, EOF, IFS, then back to IDLE.
- Standard frame:
  - ARB = SOF(0), ID[10:0], RTR.
  - CTRL = IDE(0), r0(0), DLC[3:0].
- Extended frame:
  - ARB = SOF, ID[28:18], SRR(1), IDE(1), ID[17:0], RTR.
  - CTRL = r1(0), r0(0), DLC[3:0].
- Data field:
  - Payload bytes = min(DLC, 8); the DLC field itself is sent unmodified.
  - RTR=1 sends 0 data bits.
- CRC-15:
  - Polynomial 0x4599, initial value 0.
  - Computed over unstuffed bits from SOF to the end of DATA.
  - Sent MSB first.
- Bit stuffing:
  - Active from SOF to the last CRC bit.
  - After 5 consecutive equal bits (stuff bits count toward the run), insert the complement.
  - Stuff bits are excluded from the CRC.
  - A stuff bit due after the last CRC bit is still sent.
- Fixed tail: CRC_DELIM 1, ACK 1 (expect dominant), ACK_DELIM 1, EOF 7×1, IFS 3×1.
- Arbitration:
  - Applies to non-stuff bits in ARB only.
  - If bit_out=1 and the sampled bit_in=0: pulse tx_arb_lost, drive bit_out=1 from the next cycle, and go to IDLE with no tx_complete.
- ACK:
  - A sampled bit_in=1 in the ACK slot latches the ack-error flag.
  - The frame still runs to the end of IFS; the flag is presented on tx_ack_err with tx_complete.
- Readback is otherwise ignored: no bit error or stuff error detection.

## Timing
- Acceptance: tx_req is sampled in cycle N. tx_busy=1 and SOF is driven from cycle N+1.
- Bit length: each bit holds bit_out for exactly BIT_CYCLES cycles. bit_in is sampled on the cycle where the bit counter equals SAMPLE_PT.
- Frame length in bits = fixed fields + 8×payload bytes + 15 + stuff bits + 13.
  - Fixed fields: 19 for standard, 39 for extended.
- Completion: tx_complete pulses on the last cycle of the last IFS bit, and tx_busy falls on the same edge.
- Back-to-back frames: a new tx_req is accepted on the cycle after tx_complete.
- Arbitration loss: tx_arb_lost pulses on the cycle after the sample, and tx_busy falls together with it.
- Reset mid-frame: rst low forces all outputs to their reset values immediately. init does the same on the next edge.
- Counter widths:
  - Bit counter: $clog2(BIT_CYCLES).
  - Field counter: 6 bits.
  - Stuff run counter: 3 bits.

## Structure
- Package can_pkg holds:
  - CRC_POLY = 15'h4599;
  - the state enum;
  - EOF_BITS = 7 and IFS_BITS = 3;
  - standard and extended ARB/CTRL field lengths.
- Sub-module can_crc15: serial CRC with clear, enable and data-bit inputs, plus a 15-bit output.

## Test plan
- Standard frame, BIT_CYCLES=4, ID 0x123, DLC 1, data 0xAA, bench drives the ACK slot 0 -> bitstream matches the golden stuffed model; tx_complete pulses once; tx_ack_err=0.
- ID 0x7FF, DLC 0 -> a 0 stuff bit follows the 5th consecutive 1 of the ID run; the CRC matches the model value.
- Same frame with bit_in held at bit_out everywhere (ACK recessive) -> full frame sent; tx_ack_err=1 with tx_complete.
- bit_in forced 0 during the first recessive ID bit -> tx_arb_lost pulses, bit_out=1 and tx_busy=0 next cycle, no tx_complete.
- Extended frame, ID 0x1ABCDEF, DLC 12 -> SRR=1, IDE=1, DLC field 1100, 64 data bits sent; tx_req pulses during the frame are ignored.
- rst low during the DATA field -> bit_out=1 and tx_busy=0 asynchronously; a new tx_req after release sends a clean frame from SOF.
